// File: rtl/pipe_stage_skid_reg_pkg.sv
// Shared types and constants for the generic inter-stage pipeline register.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_FULL     = 2'd1,
    ST_SKIDFULL = 2'd2
  } pipe_state_t;

  // Standard ID/EX bundle widths and their bubble (no side effect) control value
  localparam int ID_EX_CTRL_W = 24;
  localparam int ID_EX_DATA_W = 64;
  localparam logic [ID_EX_CTRL_W-1:0] ID_EX_CTRL_BUBBLE = '0;

  // Standard IF/ID bundle: no control yet, instruction word plus pc
  localparam int IF_ID_CTRL_W = 1;
  localparam int IF_ID_DATA_W = 64;
  localparam logic [IF_ID_CTRL_W-1:0] IF_ID_CTRL_BUBBLE = '0;

  // True when the stage holds at least one valid beat
  function automatic logic holds_beat(input pipe_state_t s);
    return s != ST_EMPTY;
  endfunction

endpackage

// File: rtl/pipe_stage_skid_reg_sat_counter.sv
// Saturating event counter: counts up on inc and sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Increment on each event until the counter reaches its maximum value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Generic pipeline stage register with valid/ready handshake, flush, optional
// 2-entry skid buffer, bubble control on empty and stall/flush event counters.
module pipe_stage_skid_reg
  import pipe_pkg::*;
#(
  parameter int                CTRL_W      = 24,
  parameter int                DATA_W      = 64,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter int                SKID        = 1,
  parameter int                CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  pipe_state_t       state;
  pipe_state_t       state_n;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] m_data;
  logic [CTRL_W-1:0] s_ctrl;
  logic [DATA_W-1:0] s_data;
  logic              in_fire;
  logic              load_m_in;
  logic              load_m_s;
  logic              load_s;

  assign in_fire   = in_valid & in_ready;
  assign out_valid = holds_beat(state);
  assign out_ctrl  = m_ctrl;
  assign out_data  = m_data;

  // Next-state and register load selection; flush overrides every other action
  always_comb begin
    state_n   = state;
    load_m_in = 1'b0;
    load_m_s  = 1'b0;
    load_s    = 1'b0;
    if (flush) begin
      state_n = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            load_m_in = 1'b1;
            state_n   = ST_FULL;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            if (in_fire) begin
              load_m_in = 1'b1;
            end else begin
              state_n = ST_EMPTY;
            end
          end else if (in_fire && (SKID != 0)) begin
            load_s  = 1'b1;
            state_n = ST_SKIDFULL;
          end
        end
        ST_SKIDFULL: begin
          if ((SKID != 0) && out_ready) begin
            load_m_s = 1'b1;
            state_n  = ST_FULL;
          end
        end
        default: state_n = ST_EMPTY;
      endcase
    end
  end

  // State register; reset drops every held beat immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_n;
    end
  end

  // Main register: bubble the control whenever the stage goes empty, data is kept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ctrl <= CTRL_BUBBLE;
      m_data <= '0;
    end else if (state_n == ST_EMPTY) begin
      m_ctrl <= CTRL_BUBBLE;
    end else if (load_m_in) begin
      m_ctrl <= in_ctrl;
      m_data <= in_data;
    end else if (load_m_s) begin
      m_ctrl <= s_ctrl;
      m_data <= s_data;
    end
  end

  if (SKID != 0) begin : g_skid
    logic ready_q;

    // Skid register catches the beat that arrives while the head is stalled
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s_ctrl <= '0;
        s_data <= '0;
      end else if (load_s) begin
        s_ctrl <= in_ctrl;
        s_data <= in_data;
      end
    end

    // Registered ready so upstream never sees a combinational path from out_ready
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ready_q <= 1'b1;
      end else begin
        ready_q <= (state_n != ST_SKIDFULL);
      end
    end

    assign in_ready = ready_q;
  end else begin : g_noskid
    assign s_ctrl   = '0;
    assign s_data   = '0;
    assign in_ready = (state == ST_EMPTY) | out_ready;
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_valid & ~out_ready),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush & holds_beat(state)),
    .count (flush_cnt)
  );

  // An empty stage must never present a control word with side effects
  a_bubble: assert property (@(posedge clk) disable iff (rst)
    !out_valid |-> (out_ctrl == CTRL_BUBBLE));

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Self-checking bench: three stage instances (skid, no skid, skid with 4-bit
// counters) share one stimulus stream, each with its own scoreboard queue.
module tb_pipe_stage_skid_reg;

  localparam int NDUT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_data;
  logic [23:0] in_ctrl;
  logic        flush;
  logic        out_ready;

  logic        in_ready_a  [NDUT];
  logic        out_valid_a [NDUT];
  logic [23:0] out_ctrl_a  [NDUT];
  logic [63:0] out_data_a  [NDUT];
  logic [15:0] stall_a     [NDUT];
  logic [15:0] flush_a     [NDUT];

  int n_checks = 0;
  int n_fail   = 0;

  // Free-running clock
  always #5 clk = ~clk;

  // Control word derived from data so every real beat has a non-bubble control
  assign in_ctrl = {in_data[15:0], 8'h5A};

  // Count one comparison and report it if the observed value is wrong
  task automatic checkOutput(input string tag, input int inst,
                             input logic [87:0] actual, input logic [87:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL dut%0d %s: got %0h, expected %0h", inst, tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs and advance past the next rising edge
  task automatic applyStimulus(input logic v, input logic [63:0] d,
                               input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    @(posedge clk);
    #1;
  endtask

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    localparam int SK   = (k == 1) ? 0 : 1;
    localparam int CW   = (k == 2) ? 4 : 16;
    localparam int CMAX = (1 << CW) - 1;

    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
    logic [87:0]   exp_q [$];
    int            exp_stall;
    int            exp_flush;
    logic          exp_valid;
    logic          exp_ready;

    pipe_stage_skid_reg #(
      .CTRL_W      (24),
      .DATA_W      (64),
      .CTRL_BUBBLE (24'h0),
      .SKID        (SK),
      .CNT_W       (CW)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready_a[k]),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .flush     (flush),
      .out_valid (out_valid_a[k]),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl_a[k]),
      .out_data  (out_data_a[k]),
      .stall_cnt (sc),
      .flush_cnt (fc)
    );

    assign stall_a[k] = 16'(sc);
    assign flush_a[k] = 16'(fc);

    // Scoreboard: compare head and status mid-cycle, then apply this cycle's transfers
    always @(negedge clk) begin
      if (rst) begin
        exp_q.delete();
        exp_stall = 0;
        exp_flush = 0;
      end else begin
        exp_valid = (exp_q.size() != 0);
        exp_ready = (SK != 0) ? (exp_q.size() < 2) : (!exp_valid || out_ready);
        checkOutput("out_valid", k, 88'(out_valid_a[k]), 88'(exp_valid));
        checkOutput("in_ready", k, 88'(in_ready_a[k]), 88'(exp_ready));
        checkOutput("stall_cnt", k, 88'(stall_a[k]), 88'(exp_stall));
        checkOutput("flush_cnt", k, 88'(flush_a[k]), 88'(exp_flush));
        if (exp_valid) begin
          checkOutput("head_beat", k, {out_ctrl_a[k], out_data_a[k]}, exp_q[0]);
        end
        if (!out_valid_a[k]) begin
          checkOutput("bubble_ctrl", k, 88'(out_ctrl_a[k]), 88'(0));
        end
        if (exp_valid && !out_ready && (exp_stall < CMAX)) exp_stall++;
        if (flush && exp_valid && (exp_flush < CMAX)) exp_flush++;
        if (exp_valid && out_ready) void'(exp_q.pop_front());
        if (flush) begin
          exp_q.delete();
        end else if (in_valid && exp_ready) begin
          exp_q.push_back({in_ctrl, in_data});
        end
      end
    end
  end

  // Directed phases followed by a long random phase
  initial begin
    logic [63:0] seq;
    logic        rv;
    logic        rr;
    logic        rf;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      checkOutput("reset_in_ready", k, 88'(in_ready_a[k]), 88'(1));
      checkOutput("reset_out_valid", k, 88'(out_valid_a[k]), 88'(0));
      checkOutput("reset_out_data", k, 88'(out_data_a[k]), 88'(0));
    end

    $display("[TB] streaming 1..100");
    for (int i = 1; i <= 100; i++) applyStimulus(1'b1, 64'(i), 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < NDUT; k++) begin
      checkOutput("stream_stall_cnt", k, 88'(stall_a[k]), 88'(0));
    end

    $display("[TB] stall and skid");
    applyStimulus(1'b1, 64'hA, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'hB, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'hC, 1'b0, 1'b0);
    for (int k = 0; k < NDUT; k++) begin
      checkOutput("stall_in_ready", k, 88'(in_ready_a[k]), 88'(0));
    end
    applyStimulus(1'b1, 64'hC, 1'b0, 1'b0);
    for (int k = 0; k < NDUT; k++) begin
      checkOutput("stall_cnt_3", k, 88'(stall_a[k]), 88'(3));
    end
    applyStimulus(1'b1, 64'hC, 1'b1, 1'b0);
    applyStimulus(1'b1, 64'hC, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < NDUT; k++) begin
      checkOutput("stall_cnt_hold", k, 88'(stall_a[k]), 88'(3));
    end

    $display("[TB] flush");
    applyStimulus(1'b1, 64'h10, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h11, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h12, 1'b0, 1'b1);
    for (int k = 0; k < NDUT; k++) begin
      checkOutput("flush_out_valid", k, 88'(out_valid_a[k]), 88'(0));
      checkOutput("flush_out_ctrl", k, 88'(out_ctrl_a[k]), 88'(0));
      checkOutput("flush_in_ready", k, 88'(in_ready_a[k]), 88'(1));
      checkOutput("flush_cnt_1", k, 88'(flush_a[k]), 88'(1));
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < NDUT; k++) begin
      checkOutput("flush_empty_cnt", k, 88'(flush_a[k]), 88'(1));
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 64'h20, 1'b1, 1'b0);
    applyStimulus(1'b1, 64'h21, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      checkOutput("async_rst_out_valid", k, 88'(out_valid_a[k]), 88'(0));
      checkOutput("async_rst_out_ctrl", k, 88'(out_ctrl_a[k]), 88'(0));
      checkOutput("async_rst_stall_cnt", k, 88'(stall_a[k]), 88'(0));
      checkOutput("async_rst_flush_cnt", k, 88'(flush_a[k]), 88'(0));
    end
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      checkOutput("release_in_ready", k, 88'(in_ready_a[k]), 88'(1));
    end

    $display("[TB] counter saturation");
    applyStimulus(1'b1, 64'h30, 1'b0, 1'b0);
    repeat (20) applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("sat_stall_cnt4", 2, 88'(stall_a[2]), 88'(15));
    checkOutput("sat_stall_cnt16", 0, 88'(stall_a[0]), 88'(20));
    checkOutput("sat_stall_cnt16", 1, 88'(stall_a[1]), 88'(20));
    repeat (2) applyStimulus(1'b0, '0, 1'b1, 1'b0);

    $display("[TB] random traffic");
    seq = 64'h1000;
    for (int i = 0; i < 10000; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 3) != 0);
      rf = ($urandom_range(0, 31) == 0);
      applyStimulus(rv, seq, rr, rf);
      seq = seq + 64'd1;
    end
    repeat (4) applyStimulus(1'b0, '0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
